// File: rtl/inst_fetch.sv
// Instruction-fetch stage: program counter, imem address and IF/ID register.
// Redirects from EX (branch) and ID (jump) squash the fetched slot.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    // PC and IF/ID update; the older redirect (branch) beats the younger one.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_inst     <= NOP_INST;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            fetch_count    <= 32'd0;
        end else if (branch_taken) begin
            pc             <= {branch_target[31:2], 2'b00};
            if_id_inst     <= NOP_INST;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else if (jump) begin
            pc             <= {jump_target[31:2], 2'b00};
            if_id_inst     <= NOP_INST;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else if (stall) begin
            pc             <= pc;
        end else if (!imem_ready) begin
            if_id_inst     <= NOP_INST;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else begin
            pc             <= pc_plus4;
            if_id_inst     <= imem_data;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
            fetch_count    <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed test-plan scenarios plus
// randomized redirects/stalls/waits checked against a behavioural model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump, imem_ready;
    logic [31:0] branch_target, jump_target, imem_data;
    logic [31:0] imem_addr, if_id_inst, if_id_pc_plus4, fetch_count;
    logic        if_id_valid;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
    logic        m_valid;

    localparam logic [31:0] NOP = 32'h0000_0000;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    assign imem_data = rom(imem_addr);

    inst_fetch #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump(jump),
        .jump_target(jump_target),
        .imem_ready(imem_ready),
        .imem_data(imem_data),
        .imem_addr(imem_addr),
        .if_id_inst(if_id_inst),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid(if_id_valid),
        .fetch_count(fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural next-state from the priority rules, applied per edge.
    task automatic model_edge(input logic r, s, b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt,
                              input logic rdy);
        if (r) begin
            m_pc = 32'h0; m_inst = NOP; m_pc4 = 0; m_valid = 0; m_cnt = 0;
        end else if (b) begin
            m_pc = bt & ~32'h3; m_inst = NOP; m_pc4 = 0; m_valid = 0;
        end else if (j) begin
            m_pc = jt & ~32'h3; m_inst = NOP; m_pc4 = 0; m_valid = 0;
        end else if (s) begin
            // everything holds
        end else if (!rdy) begin
            m_inst = NOP; m_pc4 = 0; m_valid = 0;
        end else begin
            m_inst  = rom(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_valid = 1;
            m_cnt   = m_cnt + 1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    // One clock: drive, edge, update model, compare on falling edge.
    task automatic cycle(input logic r, s, b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt,
                         input logic rdy);
        reset = r; stall = s; branch_taken = b; branch_target = bt;
        jump = j; jump_target = jt; imem_ready = rdy;
        @(posedge clk);
        model_edge(r, s, b, bt, j, jt, rdy);
        @(negedge clk);
        chk("imem_addr", imem_addr, m_pc);
        chk("if_id_inst", if_id_inst, m_inst);
        chk("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        chk("fetch_count", fetch_count, m_cnt);
    endtask

    task automatic normal();
        cycle(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        m_pc = 0; m_inst = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;

        // Reset and sequential fetch
        cycle(1, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_inst", if_id_inst, NOP);
        chk("rst_pc4", if_id_pc_plus4, 32'h0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'h0);
        chk("rst_cnt", fetch_count, 32'h0);
        normal();
        chk("seq_addr4", imem_addr, 32'h4);
        chk("seq_inst0", if_id_inst, rom(32'h0));
        normal();
        chk("seq_addr8", imem_addr, 32'h8);
        chk("seq_inst1", if_id_inst, rom(32'h4));
        chk("seq_pc4", if_id_pc_plus4, 32'h8);
        chk("seq_cnt", fetch_count, 32'd2);

        // Stall at pc=8 for two cycles
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 0, 0, 0, 0, 1);
            chk("stall_addr", imem_addr, 32'h8);
            chk("stall_inst", if_id_inst, rom(32'h4));
            chk("stall_cnt", fetch_count, 32'd2);
        end
        normal();
        chk("resume_inst", if_id_inst, rom(32'h8));
        normal();
        chk("at_0x10", imem_addr, 32'h10);

        // Branch and jump together: branch wins
        cycle(0, 0, 1, 32'h40, 1, 32'h80, 1);
        chk("bj_addr", imem_addr, 32'h40);
        chk("bj_valid", {31'd0, if_id_valid}, 32'h0);
        chk("bj_inst", if_id_inst, NOP);
        normal();
        chk("bj_tgt_inst", if_id_inst, rom(32'h40));
        chk("bj_tgt_pc4", if_id_pc_plus4, 32'h44);

        // Jump during stall, misaligned target
        cycle(0, 1, 0, 0, 1, 32'h103, 1);
        chk("js_addr", imem_addr, 32'h100);
        chk("js_valid", {31'd0, if_id_valid}, 32'h0);
        normal();

        // Memory wait at top of address space, then wrap
        cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            chk("wait_addr", imem_addr, 32'hFFFF_FFFC);
            chk("wait_valid", {31'd0, if_id_valid}, 32'h0);
        end
        normal();
        chk("wrap_inst", if_id_inst, rom(32'hFFFF_FFFC));
        chk("wrap_pc4", if_id_pc_plus4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset while stall and branch are active
        cycle(1, 1, 1, 32'h200, 0, 0, 1);
        chk("mrst_addr", imem_addr, 32'h0);
        chk("mrst_valid", {31'd0, if_id_valid}, 32'h0);
        chk("mrst_cnt", fetch_count, 32'h0);
        chk("mrst_inst", if_id_inst, NOP);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            logic r, s, b, j, rdy;
            r   = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 99) < 20);
            b   = ($urandom_range(0, 99) < 8);
            j   = ($urandom_range(0, 99) < 8);
            rdy = ($urandom_range(0, 99) < 75);
            cycle(r, s, b, $urandom, j, $urandom, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
